// File: rtl/tt_proj_sel.sv
// tt_proj_sel: upstream controller for the tile user-project array.
//
// A project address is shifted in serially (MSB first) and made active on a
// commit strobe. The selected project goes through a fixed power-up sequence:
// one cycle with everything off, then enable plus clock enable with reset held
// for RST_HOLD cycles, then reset released. Every project that is not selected
// sees ena=0, clk_en=0, rst_n=0 and all-zero inputs.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   sel_sdi       serial address bit, MSB first
//   sel_shift     shift sel_sdi into the address shift register
//   sel_commit    single-cycle strobe: shifted address becomes the active one
//   ui_in         dedicated pad inputs
//   proj_ena      registered one-hot (or zero) project enable
//   proj_clk_en   registered per-project clock-gate enable (equals proj_ena)
//   proj_rst_n    registered per-project active-low reset
//   proj_ui_in    gated inputs, slice i = bits [8i+7:8i]
//   active_addr   currently committed address
//   busy          high while a switch or reset sequence is in progress
//   state_dbg     current FSM state (IDLE=0, SWITCH=1, HOLD=2, RUN=3)
//
// Handshake: sel_shift and sel_commit are plain per-cycle qualifiers with no
// ready/back-pressure; each cycle they are high is acted on. A commit in the
// same cycle as a shift captures the value before that shift.
module tt_proj_sel #(
  parameter int ADDR_W   = 5,
  parameter int N_PROJ   = 24,
  parameter int RST_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sel_sdi,
  input  logic                  sel_shift,
  input  logic                  sel_commit,
  input  logic [7:0]            ui_in,
  output logic [N_PROJ-1:0]     proj_ena,
  output logic [N_PROJ-1:0]     proj_clk_en,
  output logic [N_PROJ-1:0]     proj_rst_n,
  output logic [8*N_PROJ-1:0]   proj_ui_in,
  output logic [ADDR_W-1:0]     active_addr,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  localparam int CNT_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    HOLD   = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   sr, sr_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [CNT_W-1:0]    hold_cnt, hold_cnt_d;
  logic [N_PROJ-1:0]   ena_q, ena_d;
  logic [N_PROJ-1:0]   rst_q, rst_d;
  logic [N_PROJ-1:0]   sel_oh;

  // One-hot decode of an address; addresses at or above N_PROJ decode to zero.
  function automatic logic [N_PROJ-1:0] decode(input logic [ADDR_W-1:0] a);
    logic [N_PROJ-1:0] oh;
    oh = '0;
    for (int i = 0; i < N_PROJ; i++) begin
      if (int'(a) == i) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sr          <= '0;
      active_addr <= '0;
      hold_cnt    <= '0;
      ena_q       <= '0;
      rst_q       <= '0;
    end else begin
      state       <= state_d;
      sr          <= sr_d;
      active_addr <= addr_d;
      hold_cnt    <= hold_cnt_d;
      ena_q       <= ena_d;
      rst_q       <= rst_d;
    end
  end

  always_comb begin
    state_d    = state;
    addr_d     = active_addr;
    hold_cnt_d = hold_cnt;
    sr_d       = sr;

    // The shift register runs regardless of state; commit below reads the
    // pre-shift value of sr.
    if (sel_shift) sr_d = {sr[ADDR_W-2:0], sel_sdi};

    if (sel_commit) begin
      // A commit from any state restarts the sequence, including re-commit
      // of the same address (re-reset of the running project).
      addr_d  = sr;
      state_d = SWITCH;
    end else begin
      case (state)
        IDLE: state_d = IDLE;
        SWITCH: begin
          if (int'(active_addr) < N_PROJ) begin
            state_d    = HOLD;
            hold_cnt_d = CNT_W'(RST_HOLD - 1);
          end else begin
            state_d = IDLE;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) state_d = RUN;
          else hold_cnt_d = hold_cnt - CNT_W'(1);
        end
        RUN: state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  assign sel_oh = decode(addr_d);

  always_comb begin
    ena_d = '0;
    rst_d = '0;
    if (state_d == HOLD || state_d == RUN) ena_d = sel_oh;
    if (state_d == RUN) rst_d = sel_oh;
  end

  assign proj_ena    = ena_q;
  assign proj_clk_en = ena_q;
  assign proj_rst_n  = rst_q;
  assign busy        = (state == SWITCH) || (state == HOLD);
  assign state_dbg   = state;

  // Zero-latency input gating: only the enabled project sees the pads.
  for (genvar g = 0; g < N_PROJ; g++) begin : g_ui
    assign proj_ui_in[8*g +: 8] = ena_q[g] ? ui_in : 8'h00;
  end

endmodule

// File: tb/tb_tt_proj_sel.sv
module tb_tt_proj_sel;

  localparam int ADDR_W   = 5;
  localparam int N_PROJ   = 24;
  localparam int RST_HOLD = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                sel_sdi = 1'b0;
  logic                sel_shift = 1'b0;
  logic                sel_commit = 1'b0;
  logic [7:0]          ui_in = 8'h00;
  logic [N_PROJ-1:0]   proj_ena, proj_clk_en, proj_rst_n;
  logic [8*N_PROJ-1:0] proj_ui_in;
  logic [ADDR_W-1:0]   active_addr;
  logic                busy;
  logic [1:0]          state_dbg;

  tt_proj_sel #(.ADDR_W(ADDR_W), .N_PROJ(N_PROJ), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .sel_sdi(sel_sdi), .sel_shift(sel_shift),
    .sel_commit(sel_commit), .ui_in(ui_in), .proj_ena(proj_ena),
    .proj_clk_en(proj_clk_en), .proj_rst_n(proj_rst_n), .proj_ui_in(proj_ui_in),
    .active_addr(active_addr), .busy(busy), .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Timeline view: m_since counts clock edges since the last commit
  // (-1 = nothing committed since reset).
  int               m_since = -1;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [ADDR_W-1:0] m_sr = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_since = -1;
      m_addr  = '0;
      m_sr    = '0;
    end else begin
      if (sel_commit) begin
        m_addr  = m_sr;
        m_since = 0;
      end else if (m_since >= 0 && m_since < 1000) begin
        m_since++;
      end
      if (sel_shift) m_sr = {m_sr[ADDR_W-2:0], sel_sdi};
    end
  end

  // ---------------- per-cycle compare ----------------
  always begin
    logic [N_PROJ-1:0]   e_ena, e_rst;
    logic [8*N_PROJ-1:0] e_ui;
    logic                e_busy;
    @(posedge clk);
    #1;
    e_ena = '0;
    e_rst = '0;
    e_busy = 1'b0;
    if (m_since == 0) begin
      e_busy = 1'b1;
    end else if (m_since >= 1 && int'(m_addr) < N_PROJ) begin
      e_ena = '0;
      e_ena[m_addr] = 1'b1;
      e_busy = (m_since <= RST_HOLD);
      if (m_since >= RST_HOLD + 1) e_rst = e_ena;
    end
    e_ui = '0;
    for (int i = 0; i < N_PROJ; i++) if (e_ena[i]) e_ui[8*i +: 8] = ui_in;
    chk("model_ena", proj_ena, e_ena);
    chk("model_clk_en", proj_clk_en, e_ena);
    chk("model_rst_n", proj_rst_n, e_rst);
    chk("model_busy", busy, e_busy);
    chk("model_addr", active_addr, m_addr);
    chk("model_ui", proj_ui_in, e_ui);
    chk("onehot_ena", ($countones(proj_ena) <= 1), 1'b1);
    chk("rst_implies_ena", ((proj_rst_n & ~proj_ena) == '0), 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic shift_addr(input logic [ADDR_W-1:0] a);
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      sel_shift = 1'b1;
      sel_sdi = a[i];
      tick();
    end
    sel_shift = 1'b0;
    sel_sdi = 1'b0;
  endtask

  task automatic commit();
    sel_commit = 1'b1;
    tick();
    sel_commit = 1'b0;
  endtask

  // Counts cycles with ena high and reset held, until reset release (bounded).
  task automatic wait_run(input int idx, output int held);
    held = 0;
    for (int k = 0; k < 20; k++) begin
      if (proj_rst_n[idx]) break;
      if (proj_ena[idx]) held++;
      tick();
    end
    chk("run_reached", proj_rst_n[idx], 1'b1);
  endtask

  task automatic chk_all_off(input string name);
    chk({name, "_ena"}, proj_ena, '0);
    chk({name, "_clk_en"}, proj_clk_en, '0);
    chk({name, "_rst_n"}, proj_rst_n, '0);
    chk({name, "_ui"}, proj_ui_in, '0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int held;
    logic [8*N_PROJ-1:0] exp_ui;

    repeat (3) tick();
    rst_n = 1'b1;
    ui_in = 8'hA5;
    repeat (10) tick();
    chk_all_off("idle");
    chk("idle_busy", busy, 1'b0);

    // Project 3
    ui_in = 8'h5A;
    shift_addr(5'd3);
    commit();
    chk("p3_switch_ena", proj_ena, '0);
    chk("p3_switch_busy", busy, 1'b1);
    tick();
    chk("p3_hold_ena", proj_ena, 24'h000008);
    chk("p3_hold_rst", proj_rst_n, '0);
    wait_run(3, held);
    chk("p3_hold_cycles", held, 4);
    chk("p3_run_rst", proj_rst_n, 24'h000008);
    chk("p3_run_busy", busy, 1'b0);
    exp_ui = '0;
    exp_ui[31:24] = 8'h5A;
    chk("p3_ui", proj_ui_in, exp_ui);

    // Switch to project 7
    shift_addr(5'd7);
    commit();
    chk_all_off("p7_switch");
    tick();
    chk("p7_hold_ena", proj_ena, 24'h000080);
    wait_run(7, held);
    chk("p7_hold_cycles", held, 4);

    // Out-of-range address 30
    shift_addr(5'd30);
    commit();
    chk("a30_busy_sw", busy, 1'b1);
    chk("a30_addr", active_addr, 5'd30);
    tick();
    chk_all_off("a30_idle");
    chk("a30_busy_idle", busy, 1'b0);
    chk("a30_addr_idle", active_addr, 5'd30);

    // Commit during HOLD restarts the sequence
    shift_addr(5'd5);
    commit();
    tick();
    tick();
    chk("p5_in_hold", (proj_ena == 24'h000020) && !proj_rst_n[5], 1'b1);
    commit();
    chk_all_off("p5_restart_sw");
    tick();
    wait_run(5, held);
    chk("p5_restart_cycles", held, 4);

    // Async reset mid-HOLD
    commit();
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk_all_off("arst_hold");
    chk("arst_hold_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    chk("arst_hold_addr", active_addr, 5'd0);
    chk("arst_hold_state", state_dbg, 2'd0);

    // Async reset mid-RUN
    shift_addr(5'd2);
    commit();
    tick();
    wait_run(2, held);
    #2 rst_n = 1'b0;
    #1;
    chk_all_off("arst_run");
    tick();
    rst_n = 1'b1;
    chk("arst_run_addr", active_addr, 5'd0);

    // Commit together with shift captures the pre-shift register value
    shift_addr(5'd0);
    for (int i = 0; i < 4; i++) begin
      sel_shift = 1'b1;
      sel_sdi = (i == 3);
      tick();
    end
    sel_sdi = 1'b0;
    sel_commit = 1'b1;
    tick();
    sel_commit = 1'b0;
    sel_shift = 1'b0;
    chk("preshift_addr", active_addr, 5'd1);
    commit();
    chk("postshift_addr", active_addr, 5'd2);
    repeat (8) tick();
    chk("final_ena", proj_ena, 24'h000004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tt_proj_sel.md
Name: tt_proj_sel

Overview:
- Upstream controller for the tile user-project array. It shifts in a project address serially and commits it on a strobe.
- It sequences the selected project in one-hot fashion: enable, clock enable, then reset hold and release.
- It forces every non-selected project's inputs, clock enable and reset to zero.
- Result: each project sees exactly the guarantees the user-side connectivity proof relies on. Inactive means ena=0, inputs=0, rst_n=0, no clock. Active means inputs pass through.

Parameters:
- ADDR_W, 5, width of the project address.
- N_PROJ, 24, number of attached projects; must satisfy N_PROJ ≤ 2**ADDR_W.
- RST_HOLD, 4, cycles the selected project is held in reset with its clock running, before release; must be ≥1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sel_sdi  in  1  serial address bit, MSB first.
- sel_shift  in  1  when high, shift sel_sdi into the address shift register.
- sel_commit  in  1  single-cycle strobe: make the shifted address the active project.
- ui_in  in  8  dedicated inputs from pads.
- proj_ena  out  N_PROJ  one-hot (or zero) project enable.
- proj_clk_en  out  N_PROJ  clock-gate enable per project.
- proj_rst_n  out  N_PROJ  per-project active-low reset.
- proj_ui_in  out  8*N_PROJ  gated inputs; slice i = bits [8i+7:8i].
- active_addr  out  ADDR_W  currently committed address.
- busy  out  1  high while a switch or reset sequence is in progress.

Behaviour:
- Reset (rst_n low, asynchronous) sets the following; all outputs are inactive from reset assertion with no clock edge needed:
  - shift register = 0, active_addr = 0, state = IDLE, hold counter = 0.
  - proj_ena = 0, proj_clk_en = 0, proj_rst_n = 0, busy = 0.
- Shift register: on each clk with sel_shift=1, sr <= {sr[ADDR_W-2:0], sel_sdi}.
  - It operates independently of state and never affects outputs until commit.
  - sel_shift and sel_commit in the same cycle: commit captures the pre-shift value; the shift still takes effect.
- States: IDLE, SWITCH, HOLD, RUN.
- IDLE: no project enabled.
  - sel_commit -> latch active_addr <= sr; go to SWITCH.
- SWITCH (exactly 1 cycle):
  - proj_ena, proj_clk_en and proj_rst_n all 0; busy = 1.
  - If active_addr < N_PROJ: go to HOLD with hold counter = RST_HOLD-1.
  - Otherwise go to IDLE, nothing enabled.
- HOLD:
  - proj_ena[active_addr] = 1 and proj_clk_en[active_addr] = 1; proj_rst_n all 0; busy = 1.
  - Counter decrements each cycle; at 0 go to RUN.
- RUN:
  - proj_ena and proj_clk_en as in HOLD; proj_rst_n[active_addr] = 1; busy = 0.
- sel_commit in SWITCH, HOLD or RUN: latch new active_addr and go to SWITCH.
  - This restarts the sequence; it is legal even when the address is unchanged, giving a project re-reset.
- Timing for a commit sampled at edge t:
  - SWITCH is visible after edge t.
  - ena is visible after edge t+1.
  - rst_n is released after edge t+1+RST_HOLD.
- Output registration: proj_ena, proj_clk_en and proj_rst_n are registered; never more than one bit set in each.
- Derived invariants:
  - proj_rst_n[i] implies proj_ena[i].
  - proj_clk_en == proj_ena.
- proj_ui_in slice i = proj_ena[i] ? ui_in : 8'h00. This path is combinational and zero-latency.
- Address range: active_addr ≥ N_PROJ is a legal "all off" selection, not an error. active_addr still reports the committed value.

Test Plan:
- Reset then idle 10 cycles -> proj_ena=0, proj_rst_n=0, proj_clk_en=0, all proj_ui_in=0 with ui_in=8'hA5, busy=0.
- Shift 5'b00011 (MSB first, 5 cycles sel_shift=1), then commit -> SWITCH for 1 cycle, then proj_ena=1<<3 for 4 cycles with proj_rst_n=0, then proj_rst_n[3]=1. With ui_in=8'h5A: proj_ui_in slice 3 = 8'h5A, all other slices = 0.
- While running project 3, shift and commit 7 -> one cycle with all enables 0, then proj_ena=1<<7; project 3 never has ena and rst_n high simultaneously with project 7.
- Commit address 30 (≥ N_PROJ) -> SWITCH then IDLE; all outputs 0; active_addr=30; busy drops after 1 cycle.
- Commit during HOLD (second cycle) -> sequence restarts; full RST_HOLD=4 reset cycles observed after re-enable.
- Assert rst_n low mid-HOLD and mid-RUN -> all proj_* outputs 0 immediately, without a clock edge; after release, IDLE with active_addr=0.
